// File: rtl/csa_accum_pkg.sv
// ---------------------------------------------------------------------------
// csa_accum_pkg
//   Shared definitions for the carry-save accumulator controller:
//   - default operand / count widths
//   - FSM state encoding (IDLE/LOAD/RESOLVE/DONE, 2 bits)
// ---------------------------------------------------------------------------
package csa_accum_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/csa3_stage.sv
// ---------------------------------------------------------------------------
// csa3_stage
//   Purely combinational W-bit 3:2 compressor (bitwise full adders).
//   Ports:
//     a, b, c  in   W  three addends
//     sum      out  W  bitwise XOR of the addends (weight 1)
//     carry    out  W  bitwise majority (weight 2, NOT shifted here)
//   a + b + c == sum + (carry << 1) for the full-precision result.
// ---------------------------------------------------------------------------
module csa3_stage #(
  parameter int W = 12
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_accum_ctrl.sv
// ---------------------------------------------------------------------------
// csa_accum_ctrl
//   Sums a run of num_ops unsigned operands with a carry-save stage; the
//   redundant (S, C) pair is resolved by one carry-propagate add at the end.
//   Configuration macro: CSA_ACCUM_ABORT_EN (adds the abort input).
//   Ports:
//     clk        in   1      rising-edge clock
//     reset      in   1      asynchronous active-low reset
//     start      in   1      begin a run (sampled in IDLE only)
//     num_ops    in   CNT_W  operand count, latched with start
//     abort      in   1      (CSA_ACCUM_ABORT_EN only) drop run in LOAD/RESOLVE
//     in_valid   in   1      operand valid
//     in_ready   out  1      operand accepted on in_valid && in_ready
//     in_data    in   WIDTH  operand, unsigned
//     out_valid  out  1      result valid, held until out_ready
//     out_ready  in   1      consumer accepts result
//     out_sum    out  ACC_W  result, unsigned (ACC_W = WIDTH + CNT_W)
//     busy       out  1      high in every state except IDLE
// ---------------------------------------------------------------------------
module csa_accum_ctrl
  import csa_accum_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CNT_W-1:0]       num_ops,
`ifdef CSA_ACCUM_ABORT_EN
  input  logic                   abort,
`endif
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH+CNT_W-1:0] out_sum,
  output logic                   busy
);

  localparam int ACC_W = WIDTH + CNT_W;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] s_q, c_q;
  logic [ACC_W-1:0] csa_sum, csa_carry;
  logic [CNT_W-1:0] count_q;
  logic             abort_hit;

  // At most 2**CNT_W-1 operands of WIDTH bits always fit in ACC_W bits, so
  // S + 2*C < 2**ACC_W and the MSB of C is always 0: shifting C left within
  // ACC_W bits loses nothing.
  csa3_stage #(.W(ACC_W)) u_csa (
    .a     (s_q),
    .b     (c_q << 1),
    .c     ({{CNT_W{1'b0}}, in_data}),
    .sum   (csa_sum),
    .carry (csa_carry)
  );

`ifdef CSA_ACCUM_ABORT_EN
  assign abort_hit = abort && ((state_q == ST_LOAD) || (state_q == ST_RESOLVE));
`else
  assign abort_hit = 1'b0;
`endif

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets its default first so no path leaves it unassigned;
  // a missing default in always_comb would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (start) state_d = (num_ops == '0) ? ST_DONE : ST_LOAD;
      ST_LOAD:    if (in_valid && (count_q == CNT_W'(1))) state_d = ST_RESOLVE;
      ST_RESOLVE: state_d = ST_DONE;
      ST_DONE:    if (out_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (abort_hit) state_d = ST_IDLE;
  end

  // Datapath. out_sum is only written when a result is produced (or a zero-
  // operand run starts), so it is stable for the whole DONE state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_q     <= '0;
      c_q     <= '0;
      count_q <= '0;
      out_sum <= '0;
    end else if (abort_hit) begin
      s_q <= '0;
      c_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            s_q     <= '0;
            c_q     <= '0;
            count_q <= num_ops;
            if (num_ops == '0) out_sum <= '0;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            s_q     <= csa_sum;
            c_q     <= csa_carry;
            count_q <= count_q - CNT_W'(1);
          end
        end
        ST_RESOLVE: out_sum <= s_q + (c_q << 1);
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_LOAD);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// ---------------------------------------------------------------------------
// tb_csa_accum_ctrl
//   Directed self-checking bench for csa_accum_ctrl (WIDTH=8, CNT_W=4).
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.
//   Define CSA_ACCUM_ABORT_EN for both RTL and bench to cover abort.
// ---------------------------------------------------------------------------
module tb_csa_accum_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  num_ops = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_sum;
  logic        busy;
`ifdef CSA_ACCUM_ABORT_EN
  logic        abort = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csa_accum_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_ops   (num_ops),
`ifdef CSA_ACCUM_ABORT_EN
    .abort     (abort),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [3:0] n);
    start   = 1'b1;
    num_ops = n;
    tick();
    start   = 1'b0;
    check("start_busy", 32'(busy), 1);
  endtask

  // Presents one operand and completes its handshake; in_valid stays high so
  // consecutive calls stream back-to-back.
  task automatic send(input logic [7:0] d);
    int k = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (in_ready !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check("send_ready", 32'(in_ready), 1);
    tick();
  endtask

  // Waits (bounded) for out_valid, checks the sum, then accepts it.
  task automatic take_result(input string tag, input logic [11:0] exp);
    int k = 0;
    while (out_valid !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    check({tag, "_valid"}, 32'(out_valid), 1);
    check({tag, "_sum"}, 32'(out_sum), 32'(exp));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle"}, 32'(busy), 0);
    check({tag, "_vlow"}, 32'(out_valid), 0);
  endtask

  task automatic run3(input string tag, input logic [7:0] a, b, c, input logic [11:0] exp);
    start_run(4'd3);
    send(a);
    send(b);
    send(c);
    in_valid = 1'b0;
    take_result(tag, exp);
  endtask

  initial begin
    // Reset state
    #1 reset = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_out_sum", 32'(out_sum), 0);
    tick();
    reset = 1'b1;
    tick();
    check("idle_busy", 32'(busy), 0);

    // 1: 45+72+56, latency from last handshake
    start_run(4'd3);
    check("t1_in_ready", 32'(in_ready), 1);
    send(8'd45);
    send(8'd72);
    send(8'd56);
    in_valid = 1'b0;
    check("t1_resolve_nv", 32'(out_valid), 0);
    check("t1_resolve_nr", 32'(in_ready), 0);
    tick();
    check("t1_lat_valid", 32'(out_valid), 1);
    take_result("t1", 12'd173);

    // 2: runs in sequence, busy low between runs
    run3("t2a", 8'd66, 8'd62, 8'd48, 12'd176);
    run3("t2b", 8'd92, 8'd85, 8'd74, 12'd251);
    run3("t2c", 8'd12, 8'd27, 8'd143, 12'd182);

    // 3: 15 x 255 with in_valid toggling
    start_run(4'd15);
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1;
      in_data  = 8'd255;
      check("t3_ready", 32'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      in_data  = 8'd0;
      tick();
    end
    take_result("t3", 12'd3825);

    // 4: zero operands, result held while out_ready low
    start_run(4'd0);
    check("t4_valid_now", 32'(out_valid), 1);
    check("t4_sum_now", 32'(out_sum), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold_valid", 32'(out_valid), 1);
      check("t4_hold_sum", 32'(out_sum), 0);
    end
    // start during the DONE handshake is ignored, then taken in IDLE
    out_ready = 1'b1;
    start     = 1'b1;
    num_ops   = 4'd1;
    tick();
    out_ready = 1'b0;
    check("t4_start_ign", 32'(busy), 0);
    tick();
    start = 1'b0;
    check("t4_start_idle", 32'(in_ready), 1);
    send(8'd7);
    in_valid = 1'b0;
    take_result("t4b", 12'd7);

    // 5: reset mid-run clears everything at once
    start_run(4'd4);
    send(8'd5);
    send(8'd9);
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("t5_in_ready", 32'(in_ready), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_out_valid", 32'(out_valid), 0);
    check("t5_out_sum", 32'(out_sum), 0);
    #2 reset = 1'b1;
    tick();
    check("t5_still_idle", 32'(busy), 0);
    run3("t5", 8'd1, 8'd2, 8'd3, 12'd6);

`ifdef CSA_ACCUM_ABORT_EN
    // 6: abort after the first operand
    start_run(4'd3);
    send(8'd4);
    in_valid = 1'b0;
    abort    = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_abort_idle", 32'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_no_valid", 32'(out_valid), 0);
    end
    start_run(4'd2);
    send(8'd10);
    send(8'd20);
    in_valid = 1'b0;
    take_result("t6", 12'd30);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
